// File: rtl/fp_norm_lshift_seq.sv
// Iterative left-normalizer: shifts a mantissa left by binary stages (2^(S-1)..1)
// until its MSB is set, reporting the shift count and the decremented, floor-saturated exponent.
module fp_norm_lshift_seq #(
  parameter int unsigned a_width  = 23,
  parameter int unsigned sh_width = 8,
  parameter int unsigned e_width  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [a_width-1:0]  a,
  input  logic [e_width-1:0]  e_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [a_width-1:0]  b,
  output logic [sh_width-1:0] cnt,
  output logic [e_width-1:0]  e_out,
  output logic                zero,
  output logic                uf
);

  localparam int unsigned S   = $clog2(a_width);
  localparam int unsigned K_W = (S > 1) ? $clog2(S) : 1;
  localparam int unsigned X_W = ((e_width > sh_width) ? e_width : sh_width) + 1;
  localparam logic [a_width-1:0] ONES = '1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state_q, state_d;
  logic [a_width-1:0]  work_q, work_d;
  logic [e_width-1:0]  exp_q, exp_d;
  logic [sh_width-1:0] acc_q, acc_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [a_width-1:0]  b_d;
  logic [sh_width-1:0] cnt_d;
  logic [e_width-1:0]  e_out_d;
  logic                zero_d, uf_d;

  logic [a_width-1:0]  stage, hi_mask, work_sh;
  logic [sh_width-1:0] acc_sh;
  logic [X_W-1:0]      acc_x, exp_x;

  // Current stage: shift by 2^k only if the top 2^k bits are all zero.
  always_comb begin
    stage   = a_width'(1) << k_q;
    hi_mask = ~(ONES >> stage);
    work_sh = work_q;
    acc_sh  = acc_q;
    if ((work_q & hi_mask) == '0) begin
      work_sh = work_q << stage;
      acc_sh  = acc_q + sh_width'(stage);
    end
    acc_x = X_W'(acc_sh);
    exp_x = X_W'(exp_q);
  end

  // Next-state and next-register values.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    exp_d   = exp_q;
    acc_d   = acc_q;
    k_d     = k_q;
    b_d     = b;
    cnt_d   = cnt;
    e_out_d = e_out;
    zero_d  = zero;
    uf_d    = uf;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d = a;
          exp_d  = e_in;
          acc_d  = '0;
          k_d    = K_W'(S - 1);
          if (a == '0) begin
            state_d = DONE;
            zero_d  = 1'b1;
            b_d     = '0;
            cnt_d   = sh_width'(a_width);
            e_out_d = '0;
            uf_d    = 1'b0;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d = work_sh;
        acc_d  = acc_sh;
        if (k_q == '0) begin
          state_d = DONE;
          b_d     = work_sh;
          cnt_d   = acc_sh;
          zero_d  = 1'b0;
          // Compare in widened arithmetic so the exponent never wraps.
          if (acc_x > exp_x) begin
            uf_d    = 1'b1;
            e_out_d = '0;
          end else begin
            uf_d    = 1'b0;
            e_out_d = e_width'(exp_x - acc_x);
          end
        end else begin
          k_d = k_q - K_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      work_q    <= '0;
      exp_q     <= '0;
      acc_q     <= '0;
      k_q       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      b         <= '0;
      cnt       <= '0;
      e_out     <= '0;
      zero      <= 1'b0;
      uf        <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      exp_q     <= exp_d;
      acc_q     <= acc_d;
      k_q       <= k_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      b         <= b_d;
      cnt       <= cnt_d;
      e_out     <= e_out_d;
      zero      <= zero_d;
      uf        <= uf_d;
    end
  end

endmodule

// File: tb/tb_fp_norm_lshift_seq.sv
// Scoreboard bench for fp_norm_lshift_seq: driver pushes model results at acceptance,
// a negedge monitor pops and compares on every output handshake.
module tb_fp_norm_lshift_seq;

  localparam int unsigned AW = 23;
  localparam int unsigned SW = 8;
  localparam int unsigned EW = 8;
  localparam int unsigned S  = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] a = '0;
  logic [EW-1:0] e_in = '0;
  logic          in_ready, out_valid, zero, uf;
  logic [AW-1:0] b;
  logic [SW-1:0] cnt;
  logic [EW-1:0] e_out;

  fp_norm_lshift_seq #(.a_width(AW), .sh_width(SW), .e_width(EW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .e_in(e_in), .out_valid(out_valid), .out_ready(out_ready),
    .b(b), .cnt(cnt), .e_out(e_out), .zero(zero), .uf(uf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] b;
    int            cnt;
    logic [EW-1:0] e;
    logic          zero;
    logic          uf;
    int            lat;
    int            acc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   rdy_mode = 0;   // 0: always ready, 1: random, 2: never
  logic ov_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk); #1;
    out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom % 2) : 1'b0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference: count leading zeros directly, then apply the exponent rule.
  function automatic exp_t model(input logic [AW-1:0] av, input logic [EW-1:0] ev, input int acc);
    exp_t r;
    int   lz;
    r.acc = acc;
    if (av == '0) begin
      r.b = '0; r.cnt = AW; r.e = '0; r.zero = 1'b1; r.uf = 1'b0; r.lat = 1;
    end else begin
      lz = 0;
      while (av[AW-1-lz] == 1'b0) lz++;
      r.b = av << lz; r.cnt = lz; r.zero = 1'b0; r.lat = S + 1;
      if (lz > int'(ev)) begin r.uf = 1'b1; r.e = '0; end
      else begin r.uf = 1'b0; r.e = EW'(int'(ev) - lz); end
    end
    return r;
  endfunction

  // Monitor: latency on rising out_valid, full result compare on handshake.
  always @(negedge clk) begin
    if (rst) begin
      ov_prev <= 1'b0;
    end else begin
      if (out_valid && !ov_prev) begin
        if (q.size() == 0) chk("unexpected_valid", 32'(out_valid), 32'd0);
        else chk("latency", 32'(cyc - q[0].acc + 1), 32'(q[0].lat));
      end
      if (out_valid && out_ready && q.size() != 0) begin
        chk("b",     32'(b),     32'(q[0].b));
        chk("cnt",   32'(cnt),   32'(q[0].cnt));
        chk("e_out", 32'(e_out), 32'(q[0].e));
        chk("zero",  32'(zero),  32'(q[0].zero));
        chk("uf",    32'(uf),    32'(q[0].uf));
        void'(q.pop_front());
      end
      ov_prev <= out_valid;
    end
  end

  task automatic send(input logic [AW-1:0] av, input logic [EW-1:0] ev, input bit junk);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    a = av; e_in = ev; in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    else q.push_back(model(av, ev, cyc + 1));
    @(posedge clk); #1;
    a = AW'($urandom); e_in = EW'($urandom); in_valid = junk;
    if (junk) begin
      repeat (3) @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (q.size() == 0) return;
    end
    chk("drain_timeout", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  initial begin
    logic [AW-1:0] av;
    logic [EW-1:0] ev;
    bit            seen;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_b", 32'(b), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_e_out", 32'(e_out), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_uf", 32'(uf), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    send(23'h000001, 8'd30, 1'b1); wait_drain();
    send(23'h400000, 8'd5,  1'b0); wait_drain();
    send(23'h000000, 8'd9,  1'b0); wait_drain();
    send(23'h000100, 8'd4,  1'b0); wait_drain();
    send(23'h7fffff, 8'd0,  1'b0); wait_drain();
    send(23'h000001, 8'd22, 1'b0); wait_drain();

    // Back-pressure: result must hold for ten cycles, then retire on one pulse.
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    send(23'h000010, 8'd50, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; break; end
    end
    if (!seen) chk("hold_valid_timeout", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10 && seen; i++) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_b", 32'(b), 32'(q[0].b));
      chk("hold_cnt", 32'(cnt), 32'(q[0].cnt));
      chk("hold_e_out", 32'(e_out), 32'(q[0].e));
      @(negedge clk);
    end
    rdy_mode = 0;
    @(negedge clk);
    @(negedge clk);
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    wait_drain();

    // Abort in the third SHIFT cycle: nothing may come out.
    send(23'h000321, 8'd100, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    @(negedge clk) rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_no_result", 32'(out_valid), 32'd0);
    send(23'h003000, 8'd20, 1'b0); wait_drain();

    // Random sweep with mixed leading-zero depths and back-pressure.
    for (int i = 0; i < 80; i++) begin
      rdy_mode = i % 2;
      if ($urandom % 8 == 0) av = '0;
      else begin
        av = AW'($urandom) >> $urandom_range(0, AW - 1);
        if (av == '0) av = AW'(1);
      end
      ev = EW'($urandom_range(0, 40));
      send(av, ev, (av != '0) && ($urandom % 4 == 0));
      wait_drain();
    end
    rdy_mode = 0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
